gain_sequencer: RTL and testbench

- Replaces the single-bit up/down gain latch with a multi-level gain controller for the tone generator output stage.
- Synchronises and debounces the up, down and mute buttons, and supports hold-to-repeat.
- Keeps a target level, and ramps the applied gain one step at a time toward that level to avoid audible clicks.
- Output `gain` drives the amplitude scaler after the tone synthesiser; `busy` tells downstream logic a ramp is in progress.

---
 rtl/gain_sequencer.sv | 254 +++++++++++++++++++++++++
 tb/tb_gain_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gain_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : gain_sequencer
// Description : Multi-level gain controller for the tone generator output
//               stage. Conditions three raw buttons (volume up, volume down,
//               mute toggle), keeps a user target level with hold-to-repeat,
//               and ramps the applied gain one step at a time toward the
//               effective target so the output never clicks.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   CLK    in   1       system clock
//   RST    in   1       synchronous active-high reset
//   btnU   in   1       raw volume-up button (asynchronous)
//   btnD   in   1       raw volume-down button (asynchronous)
//   btnC   in   1       raw mute-toggle button (asynchronous)
//   gain   out  GAIN_W  applied gain, feeds the amplitude scaler
//   level  out  GAIN_W  target level chosen by the user
//   muted  out  1       mute state
//   busy   out  1       high while gain differs from the effective target
// ============================================================================
module gain_sequencer #(
    parameter int DEBOUNCE    = 1_000_000,
    parameter int HOLD        = 50_000_000,
    parameter int REPEAT      = 12_500_000,
    parameter int RAMP_TICKS  = 100_000,
    parameter int GAIN_W      = 4,
    parameter int MAX_LEVEL   = 15,
    parameter int RESET_LEVEL = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              btnU,
    input  logic              btnD,
    input  logic              btnC,
    output logic [GAIN_W-1:0] gain,
    output logic [GAIN_W-1:0] level,
    output logic              muted,
    output logic              busy
);

    // ------------------------------------------------------------------------
    // Counter widths and terminal counts
    // ------------------------------------------------------------------------
    localparam int DB_W   = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int HR_MAX = (HOLD > REPEAT) ? HOLD : REPEAT;
    localparam int HR_W   = (HR_MAX > 1) ? $clog2(HR_MAX) : 1;
    localparam int RT_W   = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;

    localparam logic [DB_W-1:0]   c_db_last     = DB_W'(DEBOUNCE - 1);
    localparam logic [HR_W-1:0]   c_hold_last   = HR_W'(HOLD - 1);
    localparam logic [HR_W-1:0]   c_rep_last    = HR_W'(REPEAT - 1);
    localparam logic [RT_W-1:0]   c_ramp_last   = RT_W'(RAMP_TICKS - 1);
    localparam logic [GAIN_W-1:0] c_max_level   = GAIN_W'(MAX_LEVEL);
    localparam logic [GAIN_W-1:0] c_reset_level = GAIN_W'(RESET_LEVEL);

    // Button index map: 0 = up, 1 = down, 2 = mute
    logic [2:0] w_raw;
    logic [2:0] w_db;
    logic [2:0] w_press;

    assign w_raw = {btnC, btnD, btnU};

    // ------------------------------------------------------------------------
    // Input conditioning: 2-FF synchroniser, debounce, press-edge detect
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < 3; gi++) begin : g_btn
        logic            sync1_q;
        logic            sync2_q;
        logic            db_q;
        logic            db_prev_q;
        logic [DB_W-1:0] cnt_q;

        always_ff @(posedge CLK) begin
            if (RST) begin
                sync1_q   <= 1'b0;
                sync2_q   <= 1'b0;
                db_q      <= 1'b0;
                db_prev_q <= 1'b0;
                cnt_q     <= '0;
            end else begin
                sync1_q   <= w_raw[gi];
                sync2_q   <= sync1_q;
                db_prev_q <= db_q;
                // The counter only advances while the synchronised input
                // disagrees with the accepted state, so any bounce back to
                // the old value restarts the qualification window.
                if (sync2_q != db_q) begin
                    if (cnt_q == c_db_last) begin
                        db_q  <= ~db_q;
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + DB_W'(1);
                    end
                end else begin
                    cnt_q <= '0;
                end
            end
        end

        assign w_db[gi]    = db_q;
        assign w_press[gi] = db_q & ~db_prev_q;
    end

    // ------------------------------------------------------------------------
    // Up/down step source with hold-to-repeat
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_HOLDWAIT  = 2'd1,
        S_REPEATING = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [HR_W-1:0] hr_cnt_q, hr_cnt_d;
    logic            dir_dn_q, dir_dn_d;   // direction of the active sequence
    logic            w_step;
    logic            w_step_is_dn;
    logic            w_active;
    logic            w_other;
    logic            w_step_up;
    logic            w_step_dn;

    assign w_active  = dir_dn_q ? w_db[1] : w_db[0];
    assign w_other   = dir_dn_q ? w_db[0] : w_db[1];
    assign w_step_up = w_step & ~w_step_is_dn;
    assign w_step_dn = w_step &  w_step_is_dn;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            hr_cnt_q <= '0;
            dir_dn_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            hr_cnt_q <= hr_cnt_d;
            dir_dn_q <= dir_dn_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        hr_cnt_d     = hr_cnt_q;
        dir_dn_d     = dir_dn_q;
        w_step       = 1'b0;
        w_step_is_dn = dir_dn_q;

        case (state_q)
            S_IDLE: begin
                hr_cnt_d = '0;
                // A sequence starts only on a press edge of one button while
                // the other is released; simultaneous presses start nothing.
                if (w_press[0] && !w_db[1]) begin
                    w_step       = 1'b1;
                    w_step_is_dn = 1'b0;
                    dir_dn_d     = 1'b0;
                    state_d      = S_HOLDWAIT;
                end else if (w_press[1] && !w_db[0]) begin
                    w_step       = 1'b1;
                    w_step_is_dn = 1'b1;
                    dir_dn_d     = 1'b1;
                    state_d      = S_HOLDWAIT;
                end
            end

            S_HOLDWAIT, S_REPEATING: begin
                if (!w_active || w_other) begin
                    state_d  = S_IDLE;
                    hr_cnt_d = '0;
                end else if (hr_cnt_q == ((state_q == S_HOLDWAIT) ? c_hold_last
                                                                  : c_rep_last)) begin
                    w_step   = 1'b1;
                    state_d  = S_REPEATING;
                    hr_cnt_d = '0;
                end else begin
                    hr_cnt_d = hr_cnt_q + HR_W'(1);
                end
            end

            default: begin
                state_d  = S_IDLE;
                hr_cnt_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Level, mute and gain ramp
    // ------------------------------------------------------------------------
    logic [GAIN_W-1:0] level_q, level_d;
    logic [GAIN_W-1:0] gain_q, gain_d;
    logic              muted_q, muted_d;
    logic              busy_q, busy_d;
    logic [RT_W-1:0]   ramp_cnt_q, ramp_cnt_d;
    logic [GAIN_W-1:0] w_eff;
    logic [GAIN_W-1:0] w_eff_next;

    assign w_eff      = muted_q ? '0 : level_q;
    assign w_eff_next = muted_d ? '0 : level_d;

    always_comb begin
        level_d = level_q;
        if (w_step_up && (level_q != c_max_level)) begin
            level_d = level_q + GAIN_W'(1);
        end else if (w_step_dn && (level_q != '0)) begin
            level_d = level_q - GAIN_W'(1);
        end
    end

    assign muted_d = muted_q ^ w_press[2];

    // The ramp always steps toward the present effective target, so a target
    // change mid-ramp just redirects it; the tick counter keeps running.
    always_comb begin
        gain_d     = gain_q;
        ramp_cnt_d = ramp_cnt_q;
        if (gain_q == w_eff) begin
            ramp_cnt_d = '0;
        end else if (ramp_cnt_q == c_ramp_last) begin
            ramp_cnt_d = '0;
            gain_d     = (gain_q < w_eff) ? gain_q + GAIN_W'(1)
                                          : gain_q - GAIN_W'(1);
        end else begin
            ramp_cnt_d = ramp_cnt_q + RT_W'(1);
        end
    end

    // busy is registered from next-state values so it always describes the
    // gain and target visible on the outputs in the same cycle.
    assign busy_d = (gain_d != w_eff_next);

    always_ff @(posedge CLK) begin
        if (RST) begin
            level_q    <= c_reset_level;
            gain_q     <= '0;
            muted_q    <= 1'b0;
            busy_q     <= 1'b0;
            ramp_cnt_q <= '0;
        end else begin
            level_q    <= level_d;
            gain_q     <= gain_d;
            muted_q    <= muted_d;
            busy_q     <= busy_d;
            ramp_cnt_q <= ramp_cnt_d;
        end
    end

    assign gain  = gain_q;
    assign level = level_q;
    assign muted = muted_q;
    assign busy  = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_gain_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_gain_sequencer
// Description : Self-checking bench for gain_sequencer. Expected level changes
//               (value and clock edge) are queued as stimulus is applied and
//               matched against level changes recorded from the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gain_sequencer;

    localparam int DEBOUNCE    = 4;
    localparam int HOLD        = 20;
    localparam int REPEAT      = 8;
    localparam int RAMP_TICKS  = 3;
    localparam int GAIN_W      = 4;
    localparam int MAX_LEVEL   = 15;
    localparam int RESET_LEVEL = 8;
    localparam int PRESS_LAT   = 2 + DEBOUNCE;

    logic              CLK  = 1'b0;
    logic              RST  = 1'b1;
    logic              btnU = 1'b0;
    logic              btnD = 1'b0;
    logic              btnC = 1'b0;
    logic [GAIN_W-1:0] gain;
    logic [GAIN_W-1:0] level;
    logic              muted;
    logic              busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int exp_val_q[$];
    int exp_cyc_q[$];
    int obs_val_q[$];
    int obs_cyc_q[$];

    logic [GAIN_W-1:0] prev_level;
    logic              lvl_valid = 1'b0;

    gain_sequencer #(
        .DEBOUNCE    (DEBOUNCE),
        .HOLD        (HOLD),
        .REPEAT      (REPEAT),
        .RAMP_TICKS  (RAMP_TICKS),
        .GAIN_W      (GAIN_W),
        .MAX_LEVEL   (MAX_LEVEL),
        .RESET_LEVEL (RESET_LEVEL)
    ) dut (
        .CLK   (CLK),
        .RST   (RST),
        .btnU  (btnU),
        .btnD  (btnD),
        .btnC  (btnC),
        .gain  (gain),
        .level (level),
        .muted (muted),
        .busy  (busy)
    );

    always #5 CLK = ~CLK;

    // Edge counter plus level-change recorder (labels each change with the
    // number of the rising edge that produced it).
    always @(posedge CLK) begin
        cyc = cyc + 1;
        #2;
        if (!$isunknown(level)) begin
            if (lvl_valid && (level != prev_level)) begin
                obs_val_q.push_back(int'(level));
                obs_cyc_q.push_back(cyc);
            end
            prev_level = level;
            lvl_valid  = 1'b1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic sb_clear();
        exp_val_q.delete();
        exp_cyc_q.delete();
        obs_val_q.delete();
        obs_cyc_q.delete();
    endtask

    // Single press of btnU (up=1) or btnD (up=0); queues the resulting level.
    task automatic tap(input logic up, input int exp_lvl);
        exp_val_q.push_back(exp_lvl);
        exp_cyc_q.push_back(cyc + 1 + PRESS_LAT);
        if (up) btnU = 1'b1; else btnD = 1'b1;
        tick(8);
        btnU = 1'b0;
        btnD = 1'b0;
        tick(8);
    endtask

    task automatic test_reset();
        RST = 1'b1;
        tick(2);
        checks++; if (gain  !== 4'd0) begin errors++; $display("FAIL rst_gain actual %0d required 0", gain); end
        checks++; if (level !== 4'd8) begin errors++; $display("FAIL rst_level actual %0d required 8", level); end
        checks++; if (muted !== 1'b0) begin errors++; $display("FAIL rst_muted actual %0b required 0", muted); end
        checks++; if (busy  !== 1'b0) begin errors++; $display("FAIL rst_busy actual %0b required 0", busy); end
        sb_clear();
        RST = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            tick(1);
            checks++;
            if (gain !== GAIN_W'(k / RAMP_TICKS)) begin
                errors++; $display("FAIL fadein_gain k=%0d actual %0d required %0d", k, gain, k / RAMP_TICKS);
            end
            checks++;
            if (busy !== (k < 24)) begin
                errors++; $display("FAIL fadein_busy k=%0d actual %0b required %0b", k, busy, (k < 24));
            end
        end
        checks++; if (level !== 4'd8) begin errors++; $display("FAIL fadein_level actual %0d required 8", level); end
        checks++; if (muted !== 1'b0) begin errors++; $display("FAIL fadein_muted actual %0b required 0", muted); end
        checks++; if (obs_val_q.size() != 0) begin errors++; $display("FAIL fadein_levelchg actual %0d required 0", obs_val_q.size()); end
    endtask

    task automatic test_debounce();
        logic [10:0] pat;
        int ev, ec, ov, oc;
        pat = 11'b11010100111;
        sb_clear();
        for (int i = 0; i < 11; i++) begin
            btnU = pat[10-i];
            tick(1);
        end
        btnU = 1'b0;
        tick(12);
        checks++; if (level !== 4'd8) begin errors++; $display("FAIL chatter_level actual %0d required 8", level); end
        exp_val_q.push_back(9);
        exp_cyc_q.push_back(cyc + 1 + PRESS_LAT);
        btnU = 1'b1;
        tick(10);
        btnU = 1'b0;
        tick(20);
        checks++;
        if (obs_val_q.size() != exp_val_q.size()) begin
            errors++; $display("FAIL debounce_sb_count actual %0d required %0d", obs_val_q.size(), exp_val_q.size());
        end
        while (exp_val_q.size() > 0 && obs_val_q.size() > 0) begin
            ev = exp_val_q.pop_front(); ec = exp_cyc_q.pop_front();
            ov = obs_val_q.pop_front(); oc = obs_cyc_q.pop_front();
            checks++;
            if (ov !== ev || oc !== ec) begin
                errors++; $display("FAIL debounce_sb actual level %0d @%0d required level %0d @%0d", ov, oc, ev, ec);
            end
        end
        checks++; if (gain !== 4'd9) begin errors++; $display("FAIL debounce_gain actual %0d required 9", gain); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL debounce_busy actual %0b required 0", busy); end
    endtask

    task automatic test_repeat();
        int ev, ec, ov, oc, t0;
        sb_clear();
        for (int l = 10; l <= 13; l++) tap(1'b1, l);
        t0 = cyc + 1;
        exp_val_q.push_back(14); exp_cyc_q.push_back(t0 + PRESS_LAT);
        exp_val_q.push_back(15); exp_cyc_q.push_back(t0 + PRESS_LAT + HOLD);
        btnU = 1'b1;
        tick(60);
        btnU = 1'b0;
        tick(40);
        checks++;
        if (obs_val_q.size() != exp_val_q.size()) begin
            errors++; $display("FAIL repeat_sb_count actual %0d required %0d", obs_val_q.size(), exp_val_q.size());
        end
        while (exp_val_q.size() > 0 && obs_val_q.size() > 0) begin
            ev = exp_val_q.pop_front(); ec = exp_cyc_q.pop_front();
            ov = obs_val_q.pop_front(); oc = obs_cyc_q.pop_front();
            checks++;
            if (ov !== ev || oc !== ec) begin
                errors++; $display("FAIL repeat_sb actual level %0d @%0d required level %0d @%0d", ov, oc, ev, ec);
            end
        end
        checks++; if (level !== 4'd15) begin errors++; $display("FAIL repeat_level actual %0d required 15", level); end
        checks++; if (gain  !== 4'd15) begin errors++; $display("FAIL repeat_gain actual %0d required 15", gain); end
    endtask

    task automatic test_overlap();
        int ev, ec, ov, oc;
        sb_clear();
        tap(1'b0, 14);
        btnU = 1'b1; btnD = 1'b1;
        tick(20);
        btnD = 1'b0;
        tick(30);
        btnU = 1'b0;
        tick(15);
        exp_val_q.push_back(15);
        exp_cyc_q.push_back(cyc + 1 + PRESS_LAT);
        btnU = 1'b1;
        tick(10);
        btnD = 1'b1;
        tick(30);
        btnU = 1'b0; btnD = 1'b0;
        tick(15);
        checks++;
        if (obs_val_q.size() != exp_val_q.size()) begin
            errors++; $display("FAIL overlap_sb_count actual %0d required %0d", obs_val_q.size(), exp_val_q.size());
        end
        while (exp_val_q.size() > 0 && obs_val_q.size() > 0) begin
            ev = exp_val_q.pop_front(); ec = exp_cyc_q.pop_front();
            ov = obs_val_q.pop_front(); oc = obs_cyc_q.pop_front();
            checks++;
            if (ov !== ev || oc !== ec) begin
                errors++; $display("FAIL overlap_sb actual level %0d @%0d required level %0d @%0d", ov, oc, ev, ec);
            end
        end
    endtask

    task automatic test_mute();
        int ev, ec, ov, oc, n, gmax;
        sb_clear();
        for (int l = 14; l >= 10; l--) tap(1'b0, l);
        tick(30);
        checks++; if (gain !== 4'd10) begin errors++; $display("FAIL mute_pre_gain actual %0d required 10", gain); end
        btnC = 1'b1; tick(8); btnC = 1'b0;
        checks++; if (muted !== 1'b1) begin errors++; $display("FAIL mute_on actual %0b required 1", muted); end
        n = 0;
        while (gain !== 4'd6 && n < 100) begin tick(1); n++; end
        checks++; if (gain !== 4'd6) begin errors++; $display("FAIL mute_fade_timeout actual %0d required 6", gain); end
        btnC = 1'b1; tick(8); btnC = 1'b0;
        checks++; if (muted !== 1'b0) begin errors++; $display("FAIL mute_off actual %0b required 0", muted); end
        gmax = 0;
        for (int i = 0; i < 60; i++) begin
            tick(1);
            if (int'(gain) > gmax) gmax = int'(gain);
        end
        checks++; if (gmax !== 10) begin errors++; $display("FAIL unmute_peak actual %0d required 10", gmax); end
        checks++; if (gain !== 4'd10) begin errors++; $display("FAIL unmute_gain actual %0d required 10", gain); end
        btnC = 1'b1; tick(8); btnC = 1'b0;
        tick(40);
        checks++; if (gain !== 4'd0) begin errors++; $display("FAIL muted_gain actual %0d required 0", gain); end
        exp_val_q.push_back(9);
        exp_cyc_q.push_back(cyc + 1 + PRESS_LAT);
        gmax = 0;
        btnD = 1'b1;
        for (int i = 0; i < 28; i++) begin
            if (i == 8) btnD = 1'b0;
            tick(1);
            if (int'(gain) > gmax) gmax = int'(gain);
        end
        checks++; if (gmax !== 0) begin errors++; $display("FAIL muted_step_gain actual %0d required 0", gmax); end
        checks++; if (muted !== 1'b1) begin errors++; $display("FAIL muted_stays actual %0b required 1", muted); end
        checks++;
        if (obs_val_q.size() != exp_val_q.size()) begin
            errors++; $display("FAIL mute_sb_count actual %0d required %0d", obs_val_q.size(), exp_val_q.size());
        end
        while (exp_val_q.size() > 0 && obs_val_q.size() > 0) begin
            ev = exp_val_q.pop_front(); ec = exp_cyc_q.pop_front();
            ov = obs_val_q.pop_front(); oc = obs_cyc_q.pop_front();
            checks++;
            if (ov !== ev || oc !== ec) begin
                errors++; $display("FAIL mute_sb actual level %0d @%0d required level %0d @%0d", ov, oc, ev, ec);
            end
        end
    endtask

    task automatic test_reset_mid();
        int ev, ec, ov, oc, t0;
        sb_clear();
        t0 = cyc + 1;
        exp_val_q.push_back(10); exp_cyc_q.push_back(t0 + PRESS_LAT);
        exp_val_q.push_back(11); exp_cyc_q.push_back(t0 + PRESS_LAT + HOLD);
        btnC = 1'b1; btnU = 1'b1;
        tick(8);
        btnC = 1'b0;
        tick(22);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL pre_reset_busy actual %0b required 1", busy); end
        exp_val_q.push_back(RESET_LEVEL); exp_cyc_q.push_back(cyc + 1);
        RST = 1'b1;
        tick(1);
        checks++; if (gain  !== 4'd0) begin errors++; $display("FAIL midrst_gain actual %0d required 0", gain); end
        checks++; if (level !== 4'd8) begin errors++; $display("FAIL midrst_level actual %0d required 8", level); end
        checks++; if (muted !== 1'b0) begin errors++; $display("FAIL midrst_muted actual %0b required 0", muted); end
        checks++; if (busy  !== 1'b0) begin errors++; $display("FAIL midrst_busy actual %0b required 0", busy); end
        for (int i = 0; i < 6; i++) begin
            tick(1);
            checks++;
            if (level !== 4'd8 || gain !== 4'd0) begin
                errors++; $display("FAIL midrst_hold i=%0d actual level %0d gain %0d required level 8 gain 0", i, level, gain);
            end
        end
        btnU = 1'b0;
        tick(2);
        RST = 1'b0;
        tick(10);
        checks++;
        if (obs_val_q.size() != exp_val_q.size()) begin
            errors++; $display("FAIL midrst_sb_count actual %0d required %0d", obs_val_q.size(), exp_val_q.size());
        end
        while (exp_val_q.size() > 0 && obs_val_q.size() > 0) begin
            ev = exp_val_q.pop_front(); ec = exp_cyc_q.pop_front();
            ov = obs_val_q.pop_front(); oc = obs_cyc_q.pop_front();
            checks++;
            if (ov !== ev || oc !== ec) begin
                errors++; $display("FAIL midrst_sb actual level %0d @%0d required level %0d @%0d", ov, oc, ev, ec);
            end
        end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_repeat();
        test_overlap();
        test_mute();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog actual timeout required completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
